// File: rtl/ones_count_sequencer.sv
// Purpose: serial-to-parallel front end and result capture for the 127-input ones counter.
// Latency: the count is valid WIDTH+SETTLE edges after the start edge when ser_valid stays high.
// Backpressure: ser_valid=0 stalls the frame; the result is held with valid=1 until ack.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   start           begins a frame (sampled in IDLE only)
//   ser_in          serial data bit
//   ser_valid       ser_in is accepted while shifting
//   word            registered bus to the counter input; first bit lands in the MSB
//   cnt_in          counter output, sampled after the settle window
//   count, err      captured count and popcount cross-check result
//   valid, ack      result handshake
//   busy            high whenever the sequencer is not idle
module ones_count_sequencer #(
    parameter int WIDTH  = 127,
    parameter int CNTW   = $clog2(WIDTH + 1),
    parameter int SETTLE = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             ser_in,
    input  logic             ser_valid,
    output logic [WIDTH-1:0] word,
    input  logic [CNTW-1:0]  cnt_in,
    output logic [CNTW-1:0]  count,
    output logic             valid,
    input  logic             ack,
    output logic             busy,
    output logic             err
);

    // Settle counter holds SETTLE-1; keep at least one bit so SETTLE=1 still elaborates.
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int IW = 7;

    localparam logic [IW-1:0] LAST_IDX    = IW'(WIDTH - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_SETTLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   bit_idx;
    logic [CNTW-1:0] ref_cnt;
    logic [SW-1:0]   settle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            word       <= '0;
            count      <= '0;
            ref_cnt    <= '0;
            bit_idx    <= '0;
            settle_cnt <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    // word keeps the previous frame until a new one starts
                    if (start) begin
                        bit_idx <= '0;
                        ref_cnt <= '0;
                        word    <= '0;
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (ser_valid) begin
                        // Left shift: the earliest bit migrates up to the MSB.
                        word    <= {word[WIDTH-2:0], ser_in};
                        ref_cnt <= ref_cnt + CNTW'(ser_in);
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == LAST_IDX) begin
                            settle_cnt <= SETTLE_LOAD;
                            state      <= S_SETTLE;
                        end
                    end
                end

                S_SETTLE: begin
                    // word is frozen here, giving the combinational counter
                    // SETTLE full cycles to resolve before cnt_in is sampled.
                    if (settle_cnt == '0) begin
                        count <= cnt_in;
                        err   <= (cnt_in != ref_cnt);
                        valid <= 1'b1;
                        state <= S_HOLD;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end

                S_HOLD: begin
                    if (ack) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end

                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ones_count_sequencer.md
# ones_count_sequencer

Sequential front/back end for the 127-input combinational ones counter. Collects a 127-bit word from a serial bit stream and drives it onto the counter's input bus. Holds the bus stable for a programmable settle window that covers the counter's worst-case propagation, then captures the 7-bit count and presents it under a valid/ack handshake. An internal running popcount cross-checks the counter and flags any mismatch.

## Interface
- `WIDTH`, 127: word width; must equal the counter input width.
- `CNTW`, 7: count width, `$clog2(WIDTH+1)`.
- `SETTLE`, 24: clock cycles to wait after the word is complete before capturing the count. Minimum 1. The default covers 222 ns of counter delay at a 10 ns clock.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a frame; sampled only in IDLE.
- `ser_in`  in  1  serial data bit.
- `ser_valid`  in  1  `ser_in` is accepted on edges where this is 1 and state is SHIFT.
- `word`  out  WIDTH  registered bus to the counter input `A`.
- `cnt_in`  in  CNTW  counter output `N`.
- `count`  out  CNTW  captured count.
- `valid`  out  1  `count` and `err` are valid.
- `ack`  in  1  consumer accepts the result; sampled only while `valid`=1.
- `busy`  out  1  state != IDLE.
- `err`  out  1  captured `cnt_in` differs from the internal popcount.

## Operation
- The FSM has four states: IDLE, SHIFT, SETTLE, HOLD.
- **IDLE**
  - On `start`=1, clear `bit_idx`, `ref_cnt` and `word`, then go to SHIFT.
  - While in IDLE, `word` holds its last value.
- **SHIFT**
  - On each edge with `ser_valid`=1: `word <= {word[WIDTH-2:0], ser_in}`, `ref_cnt <= ref_cnt + ser_in`, `bit_idx <= bit_idx + 1`.
  - When the accepted bit has `bit_idx`==WIDTH-1, go to SETTLE and load `settle_cnt` with SETTLE-1.
  - The first bit received ends in `word[126]`; the last bit ends in `word[0]`.
  - `ser_valid`=0 stalls the frame with no state change. There is no timeout.
- **SETTLE**
  - `word` is frozen.
  - `settle_cnt` decrements each cycle.
  - On the edge where `settle_cnt`==0: `count <= cnt_in`, `err <= (cnt_in != ref_cnt)`, `valid <= 1`, then go to HOLD.
- **HOLD**
  - `valid`, `count`, `err` and `word` are held until `ack`=1.
  - On that edge: `valid <= 0`, go to IDLE.
  - `count` and `err` keep their values until the next capture.
- `start` outside IDLE is ignored. `ser_valid` outside SHIFT is ignored.
- Widths:
  - `ref_cnt` is CNTW bits and cannot overflow, since the maximum is 127.
  - `bit_idx` is 7 bits.
  - `settle_cnt` is `$clog2(SETTLE)` bits, with a minimum of 1.
- **Reset**, in any state including mid-frame: state=IDLE; `word`, `count`, `ref_cnt`, `bit_idx`, `settle_cnt` = 0; `valid`=0, `err`=0, `busy`=0. A partial frame is discarded.

## Timing
- `start` sampled at edge t puts the block in SHIFT from t+1. The first bit can be accepted at edge t+1.
- With `ser_valid` held at 1, the last bit is accepted at edge t+127.
- `valid` rises SETTLE edges after the last-bit edge, i.e. at edge t+127+SETTLE.
- `word` changes only on SHIFT-accepting edges and on the clearing edge out of IDLE. It is stable for at least SETTLE full cycles before capture.
- `ack` sampled at edge u drops `valid` and returns to IDLE at u. The earliest next `start` is sampled at u+1.
- `ack` high on the same cycle `valid` first rises is not seen until the next edge: one HOLD cycle is the minimum.
- `busy` is registered and tracks the state.

## Test plan
- **All zeros:** `start`, then 127 zeros with `ser_valid`=1 and `cnt_in` driven by the real counter → `word`=0; `count`=0, `err`=0; `valid` rises exactly 127+24 cycles after the `start` edge.
- **All ones with a gapped stream:** 127 ones with `ser_valid` toggling 1,0,1,0… → `word`=all ones after 127 accepted bits; `count`=127, `err`=0; `busy`=1 throughout.
- **Ordering:** a single 1 sent first, then 126 zeros → `word[126]`=1, every other bit 0, `count`=1. Repeat with the single 1 sent last → `word[0]`=1.
- **Mismatch:** alternating 1,0 pattern (64 ones) with `cnt_in` forced to 63 → `count`=63, `err`=1. Hold `ack`=0 for 10 cycles → `valid`, `count` and `word` stay stable; after `ack`, `valid`=0 and `busy`=0.
- **Reset mid-frame:** assert `rst` after 50 bits → the next edge shows IDLE, `word`=0, `valid`=0. A following full frame of 127 ones gives `count`=127.
- **Protocol abuse:** `start` pulsed during SHIFT, SETTLE and HOLD → no effect. `ack` pulsed while `valid`=0 → no effect. `ser_valid`=1 in IDLE → `word` is unchanged.
